// File: rtl/switch_alloc_rr_3port_pkg.sv
// Shared definitions for the 3-port border router switch allocator:
// port indices, 2-bit request encoding and crossbar select codes.
package switch_alloc_rr_3port_pkg;

   localparam int PORT_X     = 0;
   localparam int PORT_Y     = 1;
   localparam int PORT_LOCAL = 2;

   localparam logic [1:0] REQ_X       = 2'd0;
   localparam logic [1:0] REQ_Y       = 2'd1;
   localparam logic [1:0] REQ_LOCAL   = 2'd2;
   localparam logic [1:0] REQ_ILLEGAL = 2'd3;

   // Crossbar select codes; SW_STOP parks the output mux.
   localparam logic [2:0] SW_STOP  = 3'b000;
   localparam logic [2:0] SW_X1    = 3'b001;
   localparam logic [2:0] SW_Y1    = 3'b010;
   localparam logic [2:0] SW_LOCAL = 3'b100;

   function automatic logic [2:0] port_to_sw(input logic [1:0] idx);
      logic [2:0] code;
      case (idx)
         REQ_X:     code = SW_X1;
         REQ_Y:     code = SW_Y1;
         REQ_LOCAL: code = SW_LOCAL;
         default:   code = SW_STOP;
      endcase
      return code;
   endfunction

   function automatic logic [1:0] onehot3_to_idx(input logic [2:0] oh);
      logic [1:0] idx;
      case (oh)
         3'b010:  idx = 2'd1;
         3'b100:  idx = 2'd2;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic [1:0] next_ptr(input logic [1:0] idx);
      logic [1:0] nxt;
      case (idx)
         2'd0:    nxt = 2'd1;
         2'd1:    nxt = 2'd2;
         default: nxt = 2'd0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/switch_alloc_rr_3port_rr_arb3.sv
// Three-request round-robin arbiter with a lowest-index priority override.
// Purely combinational; the allocator registers the result.
module switch_alloc_rr_3port_rr_arb3 (
   input  logic [2:0] req,
   input  logic [2:0] pri,
   input  logic [1:0] ptr,
   output logic [2:0] gnt
);

   logic [2:0] rr_s;
   logic [2:0] pri_s;

   // Rotating search from ptr, overridden by any priority (starved) request.
   always_comb begin
      rr_s  = 3'b000;
      pri_s = 3'b000;
      case (ptr)
         2'd0:    rr_s = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
         2'd1:    rr_s = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
         2'd2:    rr_s = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
         default: rr_s = 3'b000;
      endcase
      pri_s = pri[0] ? 3'b001 : pri[1] ? 3'b010 : pri[2] ? 3'b100 : 3'b000;
      gnt   = (|pri) ? pri_s : rr_s;
   end

endmodule

// File: rtl/switch_alloc_rr_3port.sv
// Round-robin switch allocator with starvation aging for the 3-port border
// router: one arbiter per output, registered grants/selects, per-input age.
module switch_alloc_rr_3port #(
   parameter int PORT_NUM  = 3,
   parameter int AGE_W     = 4,
   parameter int AGE_LIMIT = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PORT_NUM-1:0]   req_valid,
   input  logic [2*PORT_NUM-1:0] req_port,
   input  logic [PORT_NUM-1:0]   out_full,
   output logic [PORT_NUM-1:0]   grant,
   output logic [PORT_NUM-1:0]   out_valid,
   output logic [3*PORT_NUM-1:0] out_sel,
   output logic [PORT_NUM-1:0]   starved
);
   import switch_alloc_rr_3port_pkg::*;

   localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
   localparam logic [AGE_W-1:0] AGE_THR = AGE_W'(AGE_LIMIT);

   // grant_r doubles as the pend mask: a granted input sits out one cycle.
   logic [PORT_NUM-1:0]   grant_r;
   logic [PORT_NUM-1:0]   out_valid_r;
   logic [3*PORT_NUM-1:0] out_sel_r;
   logic [PORT_NUM-1:0]   starved_r;
   logic [1:0]            ptr_r [PORT_NUM];
   logic [AGE_W-1:0]      age_r [PORT_NUM];

   logic [1:0]            req_tgt_s    [PORT_NUM];
   logic [PORT_NUM-1:0]   tgt_full_s;
   logic [PORT_NUM-1:0]   requesting_s;
   logic [PORT_NUM-1:0]   elig_s;
   logic [2:0]            arb_req_s    [PORT_NUM];
   logic [2:0]            arb_gnt_s    [PORT_NUM];
   logic [1:0]            win_idx_s    [PORT_NUM];
   logic [1:0]            ptr_next_s   [PORT_NUM];
   logic [AGE_W-1:0]      age_next_s   [PORT_NUM];
   logic [PORT_NUM-1:0]   win_s;
   logic [PORT_NUM-1:0]   out_win_s;
   logic [3*PORT_NUM-1:0] sel_next_s;
   logic [PORT_NUM-1:0]   starved_next_s;

   // Per-input eligibility: legal target, target not full, not pending.
   always_comb begin
      req_tgt_s    = '{default: 2'd0};
      tgt_full_s   = {PORT_NUM{1'b0}};
      requesting_s = {PORT_NUM{1'b0}};
      elig_s       = {PORT_NUM{1'b0}};
      for (int i = 0; i < PORT_NUM; i++) begin
         req_tgt_s[i] = req_port[2*i +: 2];
         case (req_tgt_s[i])
            REQ_X:     tgt_full_s[i] = out_full[PORT_X];
            REQ_Y:     tgt_full_s[i] = out_full[PORT_Y];
            REQ_LOCAL: tgt_full_s[i] = out_full[PORT_LOCAL];
            default:   tgt_full_s[i] = 1'b1;
         endcase
         requesting_s[i] = req_valid[i] && (req_tgt_s[i] != REQ_ILLEGAL);
         elig_s[i]       = requesting_s[i] && !tgt_full_s[i] && !grant_r[i];
      end
   end

   // Route each eligible input onto the request vector of its target output.
   always_comb begin
      arb_req_s = '{default: 3'b000};
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int i = 0; i < PORT_NUM; i++) begin
            arb_req_s[o][i] = elig_s[i] && (req_tgt_s[i] == 2'(o));
         end
      end
   end

   for (genvar o = 0; o < PORT_NUM; o++) begin : g_arb
      switch_alloc_rr_3port_rr_arb3 u_rr_arb3 (
         .req (arb_req_s[o]),
         .pri (arb_req_s[o] & starved_r),
         .ptr (ptr_r[o]),
         .gnt (arb_gnt_s[o])
      );
   end

   // Collect winners, next select codes and pointer updates per output.
   always_comb begin
      win_s      = {PORT_NUM{1'b0}};
      out_win_s  = {PORT_NUM{1'b0}};
      sel_next_s = {PORT_NUM{SW_STOP}};
      win_idx_s  = '{default: 2'd0};
      ptr_next_s = '{default: 2'd0};
      for (int o = 0; o < PORT_NUM; o++) begin
         out_win_s[o]          = |arb_gnt_s[o];
         win_s                 = win_s | arb_gnt_s[o];
         win_idx_s[o]          = onehot3_to_idx(arb_gnt_s[o]);
         sel_next_s[3*o +: 3]  = out_win_s[o] ? port_to_sw(win_idx_s[o]) : SW_STOP;
         ptr_next_s[o]         = out_win_s[o] ? next_ptr(win_idx_s[o]) : ptr_r[o];
      end
   end

   // Wait counters: clear on grant or idle, hold on illegal target, saturate.
   always_comb begin
      age_next_s     = '{default: {AGE_W{1'b0}}};
      starved_next_s = {PORT_NUM{1'b0}};
      for (int i = 0; i < PORT_NUM; i++) begin
         if (win_s[i] || !req_valid[i]) begin
            age_next_s[i] = {AGE_W{1'b0}};
         end else if (!requesting_s[i] || (age_r[i] == AGE_MAX)) begin
            age_next_s[i] = age_r[i];
         end else begin
            age_next_s[i] = age_r[i] + AGE_W'(1);
         end
         starved_next_s[i] = (age_next_s[i] >= AGE_THR);
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_r     <= {PORT_NUM{1'b0}};
         out_valid_r <= {PORT_NUM{1'b0}};
         out_sel_r   <= {PORT_NUM{SW_STOP}};
         starved_r   <= {PORT_NUM{1'b0}};
         for (int i = 0; i < PORT_NUM; i++) begin
            ptr_r[i] <= 2'd0;
            age_r[i] <= {AGE_W{1'b0}};
         end
      end else begin
         grant_r     <= win_s;
         out_valid_r <= out_win_s;
         out_sel_r   <= sel_next_s;
         starved_r   <= starved_next_s;
         for (int i = 0; i < PORT_NUM; i++) begin
            ptr_r[i] <= ptr_next_s[i];
            age_r[i] <= age_next_s[i];
         end
      end
   end

   assign grant     = grant_r;
   assign out_valid = out_valid_r;
   assign out_sel   = out_sel_r;
   assign starved   = starved_r;

endmodule

// File: tb/tb_switch_alloc_rr_3port.sv
// Bench for switch_alloc_rr_3port: directed vector table, hand sequences for
// reset/starvation, then random traffic against a behavioural model.
module tb_switch_alloc_rr_3port;
   import switch_alloc_rr_3port_pkg::*;

   localparam int AGE_LIMIT = 12;
   localparam int AGE_SAT   = 15;
   localparam logic [8:0] SEL_IDLE = {SW_STOP, SW_STOP, SW_STOP};
   localparam logic [2:0] SW_BY_IDX [3] = '{SW_X1, SW_Y1, SW_LOCAL};

   logic       clk;
   logic       rst_n;
   logic [2:0] req_valid;
   logic [5:0] req_port;
   logic [2:0] out_full;
   logic [2:0] grant;
   logic [2:0] out_valid;
   logic [8:0] out_sel;
   logic [2:0] starved;

   int n_cmp  = 0;
   int n_fail = 0;

   switch_alloc_rr_3port dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_port  (req_port),
      .out_full  (out_full),
      .grant     (grant),
      .out_valid (out_valid),
      .out_sel   (out_sel),
      .starved   (starved)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

   // Reference model: wait counts, round-robin pointers and pending flags.
   int         m_ptr  [3];
   int         m_age  [3];
   bit         m_pend [3];
   logic [2:0] m_grant;
   logic [2:0] m_valid;
   logic [8:0] m_sel;
   logic [2:0] m_starved;

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         m_ptr[i]  = 0;
         m_age[i]  = 0;
         m_pend[i] = 1'b0;
      end
   endfunction

   function automatic void model_step(input logic [2:0] rv, input logic [5:0] rp,
                                      input logic [2:0] full);
      int tgt [3];
      bit elig [3];
      bit won [3];
      int winner;
      m_grant = 3'b000;
      m_valid = 3'b000;
      m_sel   = SEL_IDLE;
      for (int i = 0; i < 3; i++) begin
         tgt[i]  = int'(rp[2*i +: 2]);
         elig[i] = rv[i] && (tgt[i] != 3) && !full[tgt[i]] && !m_pend[i];
         won[i]  = 1'b0;
      end
      for (int o = 0; o < 3; o++) begin
         winner = -1;
         for (int i = 0; i < 3; i++)
            if (winner < 0 && elig[i] && tgt[i] == o && m_age[i] >= AGE_LIMIT) winner = i;
         for (int k = 0; k < 3; k++)
            if (winner < 0 && elig[(m_ptr[o] + k) % 3] && tgt[(m_ptr[o] + k) % 3] == o)
               winner = (m_ptr[o] + k) % 3;
         if (winner >= 0) begin
            won[winner]      = 1'b1;
            m_grant[winner]  = 1'b1;
            m_valid[o]       = 1'b1;
            m_sel[3*o +: 3]  = SW_BY_IDX[winner];
            m_ptr[o]         = (winner + 1) % 3;
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (won[i] || !rv[i]) m_age[i] = 0;
         else if (tgt[i] != 3 && m_age[i] < AGE_SAT) m_age[i] = m_age[i] + 1;
         m_starved[i] = (m_age[i] >= AGE_LIMIT);
         m_pend[i]    = won[i];
      end
   endfunction

   task automatic run_cycle(input logic [2:0] rv, input logic [5:0] rp, input logic [2:0] full);
      req_valid = rv;
      req_port  = rp;
      out_full  = full;
      model_step(rv, rp, full);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [2:0] eg, input logic [2:0] ev,
                            input logic [8:0] es, input logic [2:0] est);
      check({tag, ".grant"},   {6'd0, grant},     {6'd0, eg});
      check({tag, ".valid"},   {6'd0, out_valid}, {6'd0, ev});
      check({tag, ".sel"},     out_sel,           es);
      check({tag, ".starved"}, {6'd0, starved},   {6'd0, est});
   endtask

   typedef struct {
      string      name;
      logic [2:0] rv;
      logic [5:0] rp;
      logic [2:0] full;
      logic [2:0] grant;
      logic [2:0] valid;
      logic [8:0] sel;
      logic [2:0] starved;
   } vec_t;

   vec_t vecs [$];

   function automatic void add(input string n, input logic [2:0] rv, input logic [5:0] rp,
                               input logic [2:0] f, input logic [2:0] g, input logic [2:0] v,
                               input logic [8:0] s, input logic [2:0] st);
      vec_t e;
      e.name = n; e.rv = rv; e.rp = rp; e.full = f;
      e.grant = g; e.valid = v; e.sel = s; e.starved = st;
      vecs.push_back(e);
   endfunction

   initial begin
      rst_n     = 1'b0;
      req_valid = 3'b000;
      req_port  = 6'd0;
      out_full  = 3'b000;
      model_reset();
      #12;
      check_all("reset", 3'b000, 3'b000, SEL_IDLE, 3'b000);
      rst_n = 1'b1;

      add("idle0", 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, SEL_IDLE, 3'b000);
      add("idle1", 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, SEL_IDLE, 3'b000);
      add("single_grant", 3'b001, 6'b000001, 3'b000, 3'b001, 3'b010, {SW_STOP, SW_X1, SW_STOP}, 3'b000);
      add("single_pend",  3'b001, 6'b000001, 3'b000, 3'b000, 3'b000, SEL_IDLE, 3'b000);
      add("single_again", 3'b001, 6'b000001, 3'b000, 3'b001, 3'b010, {SW_STOP, SW_X1, SW_STOP}, 3'b000);
      add("idle2", 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, SEL_IDLE, 3'b000);
      for (int k = 0; k < 5; k++)
         add($sformatf("full_block%0d", k), 3'b101, 6'b000000, 3'b001, 3'b000, 3'b000, SEL_IDLE, 3'b000);
      add("full_release", 3'b101, 6'b000000, 3'b000, 3'b001, 3'b001, {SW_STOP, SW_STOP, SW_X1}, 3'b000);
      add("full_second",  3'b101, 6'b000000, 3'b000, 3'b100, 3'b001, {SW_STOP, SW_STOP, SW_LOCAL}, 3'b000);
      add("idle3", 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, SEL_IDLE, 3'b000);
      add("rot_x",  3'b111, 6'b101010, 3'b000, 3'b001, 3'b100, {SW_X1, SW_STOP, SW_STOP}, 3'b000);
      add("rot_y",  3'b111, 6'b101010, 3'b000, 3'b010, 3'b100, {SW_Y1, SW_STOP, SW_STOP}, 3'b000);
      add("rot_l",  3'b111, 6'b101010, 3'b000, 3'b100, 3'b100, {SW_LOCAL, SW_STOP, SW_STOP}, 3'b000);
      add("rot_x2", 3'b111, 6'b101010, 3'b000, 3'b001, 3'b100, {SW_X1, SW_STOP, SW_STOP}, 3'b000);
      add("idle4", 3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, SEL_IDLE, 3'b000);

      foreach (vecs[k]) begin
         run_cycle(vecs[k].rv, vecs[k].rp, vecs[k].full);
         check_all(vecs[k].name, vecs[k].grant, vecs[k].valid, vecs[k].sel, vecs[k].starved);
      end

      // Async reset while a grant is being computed (LOCAL pointer now at Y).
      run_cycle(3'b111, 6'b101010, 3'b000);
      check_all("rst_pre", 3'b010, 3'b100, {SW_Y1, SW_STOP, SW_STOP}, 3'b000);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("rst_async", 3'b000, 3'b000, SEL_IDLE, 3'b000);
      model_reset();
      @(posedge clk);
      #1;
      check_all("rst_hold", 3'b000, 3'b000, SEL_IDLE, 3'b000);
      rst_n = 1'b1;
      run_cycle(3'b111, 6'b101010, 3'b000);
      check_all("rst_ptr0", 3'b001, 3'b100, {SW_X1, SW_STOP, SW_STOP}, 3'b000);
      run_cycle(3'b000, 6'b000000, 3'b000);
      check_all("rst_idle", 3'b000, 3'b000, SEL_IDLE, 3'b000);

      // LOCAL waits on a full Y output past the limit and past saturation.
      for (int c = 1; c <= 17; c++) begin
         run_cycle(3'b100, 6'b010000, 3'b010);
         check_all($sformatf("starve%0d", c), 3'b000, 3'b000, SEL_IDLE,
                   (c >= AGE_LIMIT) ? 3'b100 : 3'b000);
      end
      run_cycle(3'b101, 6'b010001, 3'b000);
      check_all("starve_win", 3'b100, 3'b010, {SW_STOP, SW_LOCAL, SW_STOP}, 3'b000);
      run_cycle(3'b101, 6'b010001, 3'b000);
      check_all("starve_ptr", 3'b001, 3'b010, {SW_STOP, SW_X1, SW_STOP}, 3'b000);
      run_cycle(3'b000, 6'b000000, 3'b000);
      check_all("starve_idle", 3'b000, 3'b000, SEL_IDLE, 3'b000);

      for (int c = 0; c < 400; c++) begin
         logic [2:0] rv;
         logic [5:0] rp;
         logic [2:0] f;
         rv = 3'($urandom_range(0, 7));
         rp = 6'($urandom_range(0, 63));
         f  = {1'b0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
         run_cycle(rv, rp, f);
         check_all($sformatf("rand%0d", c), m_grant, m_valid, m_sel, m_starved);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/switch_alloc_rr_3port.md
Name: switch_alloc_rr_3port

Overview:
- Round-robin switch allocator with starvation aging for the 3-port border router (X, Y, LOCAL inputs and outputs).
- Sits between the per-input route stations and the output registers.
- Each cycle it matches requesting inputs to free outputs and issues one-cycle grants that pop the winning input's pipeline.
- Drives per-output crossbar select codes.

Parameters:
- PORT_NUM, 3, number of input and output ports (index 0=X, 1=Y, 2=LOCAL); fixed at 3 for this revision.
- AGE_W, 4, width of each per-input wait counter.
- AGE_LIMIT, 12, wait cycles after which an input becomes starved and takes priority.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  3  per-input request; bit i = input i holds a valid flit
- req_port  in  6  requested output per input, 2 bits each ([1:0]=X input); 0=X, 1=Y, 2=LOCAL, 3=illegal (treated as no request)
- out_full  in  3  per-output downstream full; LOCAL bit tied 0 by the instantiating router
- grant  out  3  registered one-cycle grant per input (pops that input)
- out_valid  out  3  registered; output o carries a flit this cycle
- out_sel  out  9  registered crossbar select per output, 3 bits each, encoded `SW_X1/`SW_Y1/`SW_LOCAL/`SW_STOP from global.v
- starved  out  3  registered; input i wait counter at or above AGE_LIMIT (debug/perf)

Behaviour:
- Reset values: grant=0, out_valid=0, out_sel=`SW_STOP for all outputs, starved=0, round-robin pointers=0, age counters=0, pend mask=0.
- Eligibility, cycle t: input i is eligible when all of the following hold:
  - req_valid[i]=1;
  - req_port[i]!=3;
  - out_full[req_port[i]]=0;
  - pend[i]=0. pend[i] is set by a grant at t-1, because upstream has not popped yet.
- Per-output arbitration, combinational in cycle t, among eligible inputs requesting output o:
  - if any of those inputs is starved, the lowest-index starved input wins;
  - otherwise round-robin starting at ptr[o]: the first eligible index ptr[o], ptr[o]+1, ... mod 3 wins.
- Each input requests exactly one output, so it gets at most one grant; no separable second stage is needed.
- Winner i on output o: at edge t+1
  - grant[i]=1;
  - out_valid[o]=1;
  - out_sel[o]=code(i);
  - ptr[o]=(i+1) mod 3;
  - pend[i]=1.
- No winner on output o: out_valid[o]=0, out_sel[o]=`SW_STOP, ptr[o] unchanged.
- Latency: request to grant/select is 1 cycle. Grant is a single-cycle pulse. pend clears the cycle after it is set, so the same input may win again at t+2.
- Aging:
  - age[i] increments each cycle input i is requesting but not granted, saturating at 2^AGE_W-1;
  - age[i] clears on grant or when req_valid[i]=0;
  - starved[i] = (age[i] >= AGE_LIMIT), registered.
- A starved win does not move ptr differently: ptr[o] is still set to winner+1.
- Full: out_full[o] rising in cycle t blocks any grant for o at t+1. Already-registered outputs are unaffected; holding the output register is the router's job.
- Reset mid-operation: all state returns to reset values immediately (async). A grant in flight is dropped; upstream FIFOs keep their data.
- Illegal req_port=3: never granted, age not incremented.

Decomposition:
- Shared package/global.v holds:
  - the port index constants (X=0, Y=1, LOCAL=2);
  - the 2-bit request encoding;
  - the existing `SW_* select codes;
  - the index-to-`SW_* mapping function.
- One sub-module, rr_arb3: 3-request round-robin plus priority-override arbiter with pointer input, one instance per output.
- Aging counters and registers live in the top.

Test Plan:
1. After reset, hold req_valid=000 -> grant=000, out_valid=000, all out_sel=`SW_STOP, starved=000.
2. Single request: X input requests Y (req_valid=001, req_port[1:0]=1) in cycle 0.
   - cycle 1: grant=001, out_valid=010, out_sel[Y]=`SW_X1;
   - cycle 2 (pend blocks): no grant;
   - cycle 3: grant=001 again.
3. Contention: all three inputs request LOCAL continuously, ptr=0 -> grants rotate X, Y, LOCAL, X across successive award cycles, with every award followed by a pend-gap for that input only.
4. Full backpressure: X and LOCAL both request output X, out_full=001 for 5 cycles.
   - grant=000 throughout;
   - on release, X input wins first (ptr=0).
5. Starvation: force ptr[Y] so LOCAL loses repeatedly; hold LOCAL requesting Y for 12 unserved cycles.
   - starved[2]=1;
   - next award on Y goes to LOCAL regardless of ptr;
   - age[2] clears.
6. Async reset asserted in the cycle a grant is computed -> grant=000 and out_valid=000 immediately, all ptr/age/pend=0 after release.
